// File: rtl/transaction_engine.sv
// Coin-ledger transfer engine: validates a transfer request, authenticates the
// sender through an external hash unit, then commits both balances on one edge.
module transaction_engine #(
  parameter int NUM_PLAYERS  = 4,
  parameter int AMOUNT_W     = 8,
  parameter int KEY_W        = 8,
  parameter int HASH_TIMEOUT = 64,
  parameter int IDX_W        = $clog2(NUM_PLAYERS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            mem_load,
  input  logic [IDX_W-1:0]                mem_index,
  input  logic [KEY_W-1:0]                mem_public_key,
  input  logic [AMOUNT_W-1:0]             mem_balance,
  input  logic                            start,
  input  logic [IDX_W-1:0]                src,
  input  logic [IDX_W-1:0]                dst,
  input  logic [AMOUNT_W-1:0]             amount,
  input  logic [KEY_W-1:0]                key,
  output logic                            hash_req,
  output logic [KEY_W-1:0]                hash_key,
  input  logic                            hash_valid,
  input  logic [KEY_W-1:0]                hash_result,
  output logic                            busy,
  output logic                            done,
  output logic [2:0]                      status,
  output logic [NUM_PLAYERS*AMOUNT_W-1:0] balances_out
);
  localparam int CNT_W = $clog2(HASH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_HASH_REQ, ST_HASH_WAIT, ST_COMMIT, ST_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [2:0]          status_reg, status_next;
  logic [IDX_W-1:0]    src_reg, dst_reg;
  logic [AMOUNT_W-1:0] amount_reg;
  logic [KEY_W-1:0]    req_key_reg, hash_key_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [AMOUNT_W-1:0] bal_reg     [NUM_PLAYERS];
  logic [KEY_W-1:0]    pub_key_reg [NUM_PLAYERS];

  logic                idx_bad;
  logic [AMOUNT_W:0]   dst_sum;
  logic                timeout_hit;

  assign idx_bad = (int'(src_reg) >= NUM_PLAYERS) || (int'(dst_reg) >= NUM_PLAYERS) ||
                   (src_reg == dst_reg);
  // One extra bit catches receiver overflow without wrapping.
  assign dst_sum     = {1'b0, bal_reg[dst_reg]} + {1'b0, amount_reg};
  assign timeout_hit = (wait_cnt_reg == CNT_W'(HASH_TIMEOUT - 1));

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        state_next = ST_DONE;
        if (idx_bad)                         status_next = 3'd3;
        else if (amount_reg == '0)           status_next = 3'd2;
        else if (bal_reg[src_reg] < amount_reg) status_next = 3'd1;
        else if (dst_sum[AMOUNT_W])          status_next = 3'd5;
        else                                 state_next  = ST_HASH_REQ;
      end
      ST_HASH_REQ: state_next = ST_HASH_WAIT;
      ST_HASH_WAIT: begin
        if (hash_valid) begin
          if (hash_result == pub_key_reg[src_reg]) begin
            state_next = ST_COMMIT;
          end else begin
            status_next = 3'd4;
            state_next  = ST_DONE;
          end
        end else if (timeout_hit) begin
          status_next = 3'd6;
          state_next  = ST_DONE;
        end
      end
      ST_COMMIT: begin
        status_next = 3'd0;
        state_next  = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      status_reg <= '0;
    end else begin
      state_reg  <= state_next;
      status_reg <= status_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      amount_reg   <= '0;
      req_key_reg  <= '0;
      hash_key_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        src_reg     <= src;
        dst_reg     <= dst;
        amount_reg  <= amount;
        req_key_reg <= key;
      end
      // Staged during CHECK so the key is already stable when hash_req rises.
      if (state_reg == ST_CHECK) hash_key_reg <= req_key_reg;
      if (state_reg == ST_HASH_REQ)       wait_cnt_reg <= '0;
      else if (state_reg == ST_HASH_WAIT) wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

  // Ledger: loader writes only while idle; commit moves funds on a single edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        bal_reg[i]     <= '0;
        pub_key_reg[i] <= '0;
      end
    end else if (state_reg == ST_IDLE && mem_load) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (int'(mem_index) == i) begin
          bal_reg[i]     <= mem_balance;
          pub_key_reg[i] <= mem_public_key;
        end
      end
    end else if (state_reg == ST_COMMIT) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (int'(src_reg) == i)      bal_reg[i] <= bal_reg[i] - amount_reg;
        else if (int'(dst_reg) == i) bal_reg[i] <= bal_reg[i] + amount_reg;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_out
    assign balances_out[gi*AMOUNT_W +: AMOUNT_W] = bal_reg[gi];
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign hash_req = (state_reg == ST_HASH_REQ);
  assign hash_key = hash_key_reg;
  assign status   = status_reg;

endmodule

// File: tb/tb_transaction_engine.sv
// Scoreboard bench for transaction_engine: a ledger model predicts each
// transfer's status, latency and balances; a monitor checks them on done.
module tb_transaction_engine;
  localparam int NP = 4;
  localparam int AW = 8;
  localparam int KW = 8;
  localparam int HT = 8;
  localparam int IW = 2;

  logic clock = 0;
  logic reset = 0;
  logic mem_load = 0;
  logic [IW-1:0] mem_index = '0;
  logic [KW-1:0] mem_public_key = '0;
  logic [AW-1:0] mem_balance = '0;
  logic start = 0;
  logic [IW-1:0] src = '0, dst = '0;
  logic [AW-1:0] amount = '0;
  logic [KW-1:0] key = '0;
  logic hash_req;
  logic [KW-1:0] hash_key;
  logic hash_valid = 0;
  logic [KW-1:0] hash_result = '0;
  logic busy, done;
  logic [2:0] status;
  logic [NP*AW-1:0] balances_out;

  transaction_engine #(
    .NUM_PLAYERS(NP), .AMOUNT_W(AW), .KEY_W(KW), .HASH_TIMEOUT(HT)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_load(mem_load), .mem_index(mem_index),
    .mem_public_key(mem_public_key), .mem_balance(mem_balance),
    .start(start), .src(src), .dst(dst), .amount(amount), .key(key),
    .hash_req(hash_req), .hash_key(hash_key),
    .hash_valid(hash_valid), .hash_result(hash_result),
    .busy(busy), .done(done), .status(status), .balances_out(balances_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int lat;
    int nreq;
    logic [NP*AW-1:0] bals;
    int t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nreq_seen = 0;
  int m_bal[NP];
  int m_key[NP];
  bit silent = 0;
  int hv_cnt = 0;
  logic [KW-1:0] hv_key = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [NP*AW-1:0] model_bals();
    logic [NP*AW-1:0] b;
    for (int i = 0; i < NP; i++) b[i*AW +: AW] = AW'(m_bal[i]);
    return b;
  endfunction

  // Reference rules: ordered request checks, then key check, then transfer.
  function automatic void predict(input int s, input int d, input int a, input int k,
                                  output exp_t e);
    if (s >= NP || d >= NP || s == d)      e.st = 3;
    else if (a == 0)                       e.st = 2;
    else if (m_bal[s] < a)                 e.st = 1;
    else if (m_bal[d] + a > (1 << AW) - 1) e.st = 5;
    else if (silent)                       e.st = 6;
    else if (((k ^ 255) & 255) != m_key[s]) e.st = 4;
    else begin
      e.st = 0;
      m_bal[s] -= a;
      m_bal[d] += a;
    end
    case (e.st)
      0:       e.lat = 6;
      4:       e.lat = 5;
      6:       e.lat = HT + 3;
      default: e.lat = 2;
    endcase
    e.nreq = (e.st == 0 || e.st == 4 || e.st == 6) ? 1 : 0;
    e.bals = model_bals();
    e.t0 = 0;
  endfunction

  // Hash unit model: result = key ^ FF, valid two cycles after hash_req.
  always @(negedge clock) begin
    if (hv_cnt == 1) begin
      hash_valid  = 1;
      hash_result = hv_key ^ 8'hFF;
    end else begin
      hash_valid  = 0;
      hash_result = KW'($urandom);
    end
    if (hv_cnt > 0) hv_cnt--;
    if (hash_req && !silent) begin
      hv_cnt = 2;
      hv_key = hash_key;
    end
  end

  // Monitor: pops the expected response whenever done is presented.
  always @(negedge clock) begin
    if (!reset) begin
      if (hash_req) nreq_seen++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 status=%0d required no done", status);
        end else begin
          mon_e = exp_q.pop_front();
          $display("txn done status=%0d latency=%0d balances=%h", status, cyc - mon_e.t0 + 1,
                   balances_out);
          chk("status", 64'(status), 64'(mon_e.st));
          chk("latency", 64'(cyc - mon_e.t0 + 1), 64'(mon_e.lat));
          chk("balances", 64'(balances_out), 64'(mon_e.bals));
          chk("hash_req_count", 64'(nreq_seen), 64'(mon_e.nreq));
        end
        nreq_seen = 0;
      end
    end
  end

  task automatic load(input int idx, input int k, input int b);
    @(negedge clock);
    mem_load = 1;
    mem_index = IW'(idx);
    mem_public_key = KW'(k);
    mem_balance = AW'(b);
    @(posedge clock);
    #1 mem_load = 0;
    m_key[idx] = k;
    m_bal[idx] = b;
  endtask

  task automatic issue(input int s, input int d, input int a, input int k);
    exp_t e;
    @(negedge clock);
    start = 1;
    src = IW'(s);
    dst = IW'(d);
    amount = AW'(a);
    key = KW'(k);
    predict(s, d, a, k, e);
    @(posedge clock);
    #1 start = 0;
    e.t0 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles required done", n);
      exp_q.delete();
    end
  endtask

  task automatic txn(input int s, input int d, input int a, input int k);
    issue(s, d, a, k);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_hash_req"}, 64'(hash_req), 64'(0));
    chk({tag, "_hash_key"}, 64'(hash_key), 64'(0));
    chk({tag, "_status"}, 64'(status), 64'(0));
    chk({tag, "_balances"}, 64'(balances_out), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      m_bal[i] = 0;
      m_key[i] = 0;
    end
    #1 reset = 1;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 0;

    // Directed scenarios
    load(0, 8'h5A, 100);
    load(1, 8'h33, 20);
    txn(0, 1, 30, 8'hA5);
    txn(0, 1, 30, 8'h00);
    load(0, 8'h5A, 100);
    load(1, 8'h33, 20);
    txn(0, 1, 101, 8'hA5);
    txn(0, 1, 0, 8'hA5);
    txn(2, 2, 5, 8'hA5);
    load(1, 8'h33, 250);
    txn(0, 1, 10, 8'hA5);
    load(0, 8'h5A, 200);
    load(1, 8'h33, 100);
    txn(0, 1, 156, 8'hA5);
    load(1, 8'h33, 245);
    txn(0, 1, 10, 8'hA5);

    // start and mem_load while busy must both be ignored
    load(0, 8'h5A, 100);
    load(1, 8'h33, 20);
    issue(0, 1, 10, 8'hA5);
    repeat (2) @(negedge clock);
    chk("busy_high", 64'(busy), 64'(1));
    start = 1;
    src = 2'd1;
    dst = 2'd0;
    amount = 8'd5;
    key = 8'hCC;
    mem_load = 1;
    mem_index = 2'd0;
    mem_balance = 8'd0;
    mem_public_key = 8'h00;
    @(posedge clock);
    #1;
    start = 0;
    mem_load = 0;
    wait_done();
    repeat (3) @(negedge clock);
    chk("ledger_after_busy", 64'(balances_out), 64'(model_bals()));

    // Silent hash unit: timeout
    silent = 1;
    txn(0, 1, 10, 8'hA5);
    silent = 0;

    // Reset while waiting for the hash; late hash_valid must be ignored
    issue(0, 1, 10, 8'hA5);
    repeat (3) @(negedge clock);
    reset = 1;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    #2 reset = 0;
    nreq_seen = 0;
    for (int i = 0; i < NP; i++) begin
      m_bal[i] = 0;
      m_key[i] = 0;
    end
    repeat (4) begin
      @(negedge clock);
      chk("post_reset_busy", 64'(busy), 64'(0));
    end
    chk("post_reset_balances", 64'(balances_out), 64'(0));

    // Randomized transfers against the ledger model
    for (int i = 0; i < NP; i++) load(i, $urandom_range(0, 255), $urandom_range(0, 255));
    for (int n = 0; n < 40; n++) begin
      int s, d, a, k;
      if (n % 10 == 9) load($urandom_range(0, NP - 1), $urandom_range(0, 255),
                            $urandom_range(0, 255));
      s = $urandom_range(0, NP - 1);
      d = $urandom_range(0, NP - 1);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 60);
      k = ($urandom_range(0, 3) != 0) ? (m_key[s] ^ 8'hFF) : $urandom_range(0, 255);
      txn(s, d, a, k);
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 ns required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/transaction_engine.md
# transaction_engine

Parametrised transaction datapath for the coin ledger. It holds balances and public keys for `NUM_PLAYERS` players and accepts one transfer request at a time (source, destination, amount, private key). A state machine sequences the request through an amount check, a key check against an external hash unit, and a ledger commit. It supersedes the fixed two-player datapath and sits between the top-level controller/memory loader and the hash unit.

## Interface
Parameters:
- `NUM_PLAYERS`, 4: ledger entries, 2..16.
- `AMOUNT_W`, 8: balance/amount width.
- `KEY_W`, 8: key width.
- `HASH_TIMEOUT`, 64: max cycles waiting for `hash_valid`, ≥1.
- `IDX_W` is derived as clog2(`NUM_PLAYERS`).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `mem_load`  in  1  write ledger entry `mem_index` this cycle.
- `mem_index`  in  IDX_W  entry to write.
- `mem_public_key`  in  KEY_W  public key for entry.
- `mem_balance`  in  AMOUNT_W  balance for entry.
- `start`  in  1  request strobe; sampled only in IDLE.
- `src`, `dst`  in  IDX_W each  sender, receiver.
- `amount`  in  AMOUNT_W  transfer amount.
- `key`  in  KEY_W  sender's private key.
- `hash_req`  out  1  one-cycle hash request.
- `hash_key`  out  KEY_W  key presented with `hash_req`, held until response or timeout.
- `hash_valid`  in  1  hash result valid.
- `hash_result`  in  KEY_W  hashed key.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  3  result code, valid with `done`, held until next `done`.
- `balances_out`  out  NUM_PLAYERS*AMOUNT_W  player i at [i*AMOUNT_W +: AMOUNT_W].

## Operation
- States: IDLE → CHECK → HASH_REQ → HASH_WAIT → COMMIT → DONE → IDLE. Reset value is IDLE.
- IDLE: `start`=1 latches `src`/`dst`/`amount`/`key` into internal registers, then goes to CHECK. `mem_load` is honoured only in IDLE and updates key and balance the next edge. If `start` and `mem_load` are both high, the load is applied and the request latches the pre-load values.
- CHECK: the first failing rule sets `status` and jumps to DONE. Rules in order:
  1. `src` or `dst` ≥ NUM_PLAYERS, or `src`==`dst` → 3.
  2. `amount`==0 → 2.
  3. balance[src] < `amount` → 1.
  4. balance[dst]+`amount` overflows AMOUNT_W (compute at AMOUNT_W+1 bits) → 5.
  - If all pass, go to HASH_REQ.
- HASH_REQ: `hash_req`=1 for exactly one cycle with `hash_key`=latched key; the timeout counter clears. Go to HASH_WAIT.
- HASH_WAIT: on `hash_valid`:
  - `hash_result`==public_key[src] → COMMIT.
  - Otherwise `status`=4 → DONE.
  - If the counter reaches HASH_TIMEOUT with no `hash_valid`, `status`=6 → DONE.
  - `hash_valid` in any other state is ignored.
- COMMIT: balance[src]-=amount and balance[dst]+=amount on the same edge; `status`=0. Go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Failed requests never modify the ledger.

## Timing
- Reset values: `busy`=0, `done`=0, `hash_req`=0, `hash_key`=0, `status`=0, all balances and keys 0, state IDLE.
- `start` is sampled at edge T. CHECK occupies T+1, HASH_REQ T+2, HASH_WAIT from T+3.
- If `hash_valid` arrives at T+3: COMMIT at T+4, `done` at T+5. This is the minimum successful latency, 5 cycles.
- A CHECK failure gives `done` at T+2.
- Timeout gives `done` HASH_TIMEOUT+1 cycles after HASH_REQ.
- `balances_out` reflects a commit from the cycle `done` is high.
- `busy` is high from T+1 through the DONE cycle. `start` is ignored while `busy`=1, and the next request can be sampled on the edge after `done`.
- Reset asserted mid-transaction: immediate return to IDLE, ledger cleared, no `done` pulse. A late `hash_valid` after reset is ignored.

## Test plan
Hash model for all scenarios: result = key ^ 8'hFF, 2-cycle response. N=4. Load P0 key 8'h5A / bal 100, P1 key 8'h33 / bal 20.
- Transfer src0→dst1, amount 30, key 8'hA5 → `done` at T+6, `status`=0, bal0=70, bal1=50.
- Same request with key 8'h00 → `status`=4, balances unchanged, `hash_req` pulsed once.
- Amount 101 from P0 → `done` at T+2, `status`=1. Amount 0 → `status`=2. src=dst=2 → `status`=3.
- P1 bal 250, transfer 10 P0→P1 → `status`=5. P0→P1 transfer 156 with P1 bal 100 → succeeds with bal1=256? Not allowed: `status`=5. Exact-fit case, P1 bal 245 + 10 = 255 → `status`=0.
- Hash model silent with HASH_TIMEOUT=8 → `status`=6 at 9 cycles after `hash_req`. Reset asserted in HASH_WAIT → all outputs at reset values, no `done`.
- `start` pulsed while `busy` and `mem_load` while `busy` → both ignored, ledger unchanged.
